// File: rtl/logical_op_sequencer_pkg.sv
// Shared definitions for the logical-operator stimulus sequencer: opcodes,
// vector table, FSM state type and result helpers.
package logical_seq_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOT = 2'd2;

  localparam int unsigned NUM_VEC = 10;
  localparam int unsigned IDX_W   = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] a;
    logic [2:0] b;
  } vec_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESENT,
    S_GAP,
    S_DONE
  } state_e;

  // Highest index first so VEC_TABLE[i] selects entry i.
  localparam vec_entry_t [NUM_VEC-1:0] VEC_TABLE = {
    {OP_NOT, 3'b100, 3'b000},
    {OP_NOT, 3'b011, 3'b000},
    {OP_NOT, 3'b000, 3'b000},
    {OP_OR,  3'b010, 3'b000},
    {OP_OR,  3'b000, 3'b100},
    {OP_OR,  3'b011, 3'b101},
    {OP_OR,  3'b000, 3'b000},
    {OP_AND, 3'b111, 3'b101},
    {OP_AND, 3'b011, 3'b101},
    {OP_AND, 3'b000, 3'b101}
  };

  function automatic logic logic_result(input vec_entry_t e);
    logic res;
    case (e.op)
      OP_AND:  res = (|e.a) && (|e.b);
      OP_OR:   res = (|e.a) || (|e.b);
      OP_NOT:  res = !(|e.a);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_group_first(input logic [IDX_W-1:0] i);
    logic first;
    if (i == '0) begin
      first = 1'b1;
    end else if (i > LAST_IDX) begin
      first = 1'b0;
    end else begin
      first = (VEC_TABLE[i].op != VEC_TABLE[i - 1'b1].op);
    end
    return first;
  endfunction

endpackage

// File: rtl/logical_op_sequencer_if.sv
// Vector presentation bus between the sequencer and the downstream evaluator.
interface logical_op_sequencer_if #(
  parameter int unsigned W = 3
) ();
  logic         vld;
  logic         rdy;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] exp_c;
  logic [3:0]   idx;
  logic         sec_start;

  modport master (
    output vld, op, a, b, exp_c, idx, sec_start,
    input  rdy
  );

  modport slave (
    input  vld, op, a, b, exp_c, idx, sec_start,
    output rdy
  );
endinterface

// File: rtl/logical_op_sequencer_rom.sv
// Combinational lookup of a table vector: zero-extended operands, expected
// result and opcode-group start flag. Out-of-range indices read as zero.
module logical_vec_rom
  import logical_seq_pkg::*;
#(
  parameter int unsigned W = 3
) (
  input  logic [IDX_W-1:0] idx,
  output logic [1:0]       op,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     exp_c,
  output logic             first
);

  vec_entry_t entry;

  always_comb begin
    entry = '0;
    if (idx <= LAST_IDX) begin
      entry = VEC_TABLE[idx];
    end
    op       = entry.op;
    a        = '0;
    a[2:0]   = entry.a;
    b        = '0;
    b[2:0]   = entry.b;
    exp_c    = '0;
    exp_c[0] = logic_result(entry);
    first    = is_group_first(idx);
  end

endmodule

// File: rtl/logical_op_sequencer.sv
// Clocked stimulus sequencer: walks the vector table, presents each vector
// with a valid/ready handshake and inserts HOLD_CYCLES idle cycles between.
module logical_op_sequencer
  import logical_seq_pkg::*;
#(
  parameter int unsigned W           = 3,
  parameter int unsigned HOLD_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  logical_op_sequencer_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     exp_q, exp_d;
  logic             sec_q, sec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] rom_idx;
  logic [1:0]       rom_op;
  logic [W-1:0]     rom_a, rom_b, rom_exp;
  logic             rom_first;
  logic             load;

  // ROM is addressed with the index about to be presented so the vector
  // fields can be registered alongside vld.
  assign rom_idx = ((state_q == S_PRESENT) || (state_q == S_GAP)) ? idx_q + 1'b1 : '0;

  logical_vec_rom #(.W(W)) u_rom (
    .idx   (rom_idx),
    .op    (rom_op),
    .a     (rom_a),
    .b     (rom_b),
    .exp_c (rom_exp),
    .first (rom_first)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    exp_d   = exp_q;
    sec_d   = sec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PRESENT;
          load    = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_PRESENT: begin
        if (bus.rdy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            vld_d   = 1'b0;
            sec_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (HOLD_CYCLES == 0) begin
            load = 1'b1;
          end else begin
            state_d = S_GAP;
            vld_d   = 1'b0;
            sec_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_PRESENT;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      idx_d = rom_idx;
      vld_d = 1'b1;
      op_d  = rom_op;
      a_d   = rom_a;
      b_d   = rom_b;
      exp_d = rom_exp;
      sec_d = rom_first;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      sec_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      sec_q   <= sec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vld       = vld_q;
  assign bus.op        = op_q;
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.exp_c     = exp_q;
  assign bus.idx       = idx_q;
  assign bus.sec_start = sec_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
